// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card SPI bus arbiter: state encoding, owner codes, widths.
package sd_pkg;

   localparam int unsigned SD_MIN_GAP = 8;
   localparam int unsigned STATE_W    = 3;
   localparam int unsigned OWNER_W    = 2;
   localparam int unsigned GAP_W      = 8;
   localparam int unsigned WD_W       = 16;

   localparam logic [STATE_W-1:0] ST_INIT     = 3'd0;
   localparam logic [STATE_W-1:0] ST_GAP      = 3'd1;
   localparam logic [STATE_W-1:0] ST_IDLE     = 3'd2;
   localparam logic [STATE_W-1:0] ST_GRANT_RD = 3'd3;
   localparam logic [STATE_W-1:0] ST_GRANT_WR = 3'd4;

   localparam logic [OWNER_W-1:0] OWN_NONE = 2'd0;
   localparam logic [OWNER_W-1:0] OWN_INIT = 2'd1;
   localparam logic [OWNER_W-1:0] OWN_RD   = 2'd2;
   localparam logic [OWNER_W-1:0] OWN_WR   = 2'd3;

   // Owner code reported for a given arbiter state.
   function automatic logic [OWNER_W-1:0] owner_of(input logic [STATE_W-1:0] st);
      logic [OWNER_W-1:0] own;
      own = OWN_NONE;
      case (st)
         ST_INIT:     own = OWN_INIT;
         ST_GRANT_RD: own = OWN_RD;
         ST_GRANT_WR: own = OWN_WR;
         default:     own = OWN_NONE;
      endcase
      return own;
   endfunction

endpackage

// File: rtl/sd_down_counter.sv
// Loadable down-counter that holds at zero; registered zero flag. Updates on the falling clock edge.
module sd_down_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             zero_q;

   // Load has priority; decrement stops at zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   // Count and zero flag registers.
   always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         zero_q  <= 1'b1;
      end else begin
         count_q <= count_d;
         zero_q  <= (count_d == '0);
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/sd_bus_arbiter.sv
// Shares the SD-card SPI bus between initialiser, read engine and write engine,
// with a CSn-high idle gap between owners and a per-grant watchdog.
module sd_bus_arbiter
   import sd_pkg::*;
#(
   parameter int unsigned IDLE_GAP    = 8,
   parameter int unsigned TIMEOUT_CYC = 4095
) (
   input  logic       SD_CK,
   input  logic       rst_n,
   input  logic       init_ok,
   input  logic       init_csn,
   input  logic       init_mosi,
   input  logic       rd_req,
   input  logic       rd_done,
   input  logic       rd_csn,
   input  logic       rd_mosi,
   input  logic       wr_req,
   input  logic       wr_done,
   input  logic       wr_csn,
   input  logic       wr_mosi,
   output logic       rd_gnt,
   output logic       wr_gnt,
   output logic       rd_abort,
   output logic       wr_abort,
   output logic       SD_CSn,
   output logic       SD_MOSI,
   output logic [1:0] owner
);

   // Gaps shorter than the protocol minimum are raised to it.
   localparam int unsigned GAP_EFF = (IDLE_GAP < SD_MIN_GAP) ? SD_MIN_GAP : IDLE_GAP;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_EFF - 1);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [WD_W-1:0]  WD_MAX   = '1;

   logic [STATE_W-1:0] state_q, state_d;
   logic               last_wr_q, last_wr_d;   // 1: write engine was served last
   logic [WD_W-1:0]    wd_q, wd_d;
   logic               rd_gnt_q, wr_gnt_q;
   logic               rd_abort_q, wr_abort_q, rd_abort_d, wr_abort_d;
   logic [OWNER_W-1:0] owner_q;
   logic               gap_load, gap_dec, gap_zero;

   sd_down_counter #(
      .WIDTH (GAP_W)
   ) u_gap_cnt (
      .clk_i      (SD_CK),
      .rst_ni     (rst_n),
      .load_i     (gap_load),
      .load_val_i (GAP_LOAD),
      .dec_i      (gap_dec),
      .zero_o     (gap_zero)
   );

   // Next-state, round-robin choice, watchdog and abort decisions.
   always_comb begin
      state_d    = state_q;
      last_wr_d  = last_wr_q;
      wd_d       = wd_q;
      gap_load   = 1'b0;
      gap_dec    = 1'b0;
      rd_abort_d = 1'b0;
      wr_abort_d = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (init_ok) begin
               state_d  = ST_GAP;
               gap_load = 1'b1;
            end
         end
         ST_GAP: begin
            if (!init_ok) begin
               state_d = ST_INIT;
            end else if (gap_zero) begin
               state_d = ST_IDLE;
            end else begin
               gap_dec = 1'b1;
            end
         end
         ST_IDLE: begin
            wd_d = '0;
            if (!init_ok) begin
               state_d = ST_INIT;
            end else if (rd_req && (!wr_req || last_wr_q)) begin
               state_d = ST_GRANT_RD;
            end else if (wr_req) begin
               state_d = ST_GRANT_WR;
            end
         end
         ST_GRANT_RD: begin
            if (wd_q != WD_MAX) wd_d = wd_q + WD_W'(1);
            if (!init_ok) begin
               state_d    = ST_INIT;
               rd_abort_d = 1'b1;
            end else if (rd_done) begin
               state_d   = ST_GAP;
               gap_load  = 1'b1;
               last_wr_d = 1'b0;
            end else if (wd_q == WD_LIMIT) begin
               state_d    = ST_GAP;
               gap_load   = 1'b1;
               rd_abort_d = 1'b1;
            end
         end
         ST_GRANT_WR: begin
            if (wd_q != WD_MAX) wd_d = wd_q + WD_W'(1);
            if (!init_ok) begin
               state_d    = ST_INIT;
               wr_abort_d = 1'b1;
            end else if (wr_done) begin
               state_d   = ST_GAP;
               gap_load  = 1'b1;
               last_wr_d = 1'b1;
            end else if (wd_q == WD_LIMIT) begin
               state_d    = ST_GAP;
               gap_load   = 1'b1;
               wr_abort_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State and registered outputs, updated on the falling SPI clock edge.
   always_ff @(negedge SD_CK or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         last_wr_q  <= 1'b1;
         wd_q       <= '0;
         rd_gnt_q   <= 1'b0;
         wr_gnt_q   <= 1'b0;
         rd_abort_q <= 1'b0;
         wr_abort_q <= 1'b0;
         owner_q    <= OWN_INIT;
      end else begin
         state_q    <= state_d;
         last_wr_q  <= last_wr_d;
         wd_q       <= wd_d;
         rd_gnt_q   <= (state_d == ST_GRANT_RD);
         wr_gnt_q   <= (state_d == ST_GRANT_WR);
         rd_abort_q <= rd_abort_d;
         wr_abort_q <= wr_abort_d;
         owner_q    <= owner_of(state_d);
      end
   end

   // Bus mux selected only by registered state; idle bus is CSn=1, MOSI=1.
   always_comb begin
      SD_CSn  = 1'b1;
      SD_MOSI = 1'b1;
      case (state_q)
         ST_INIT: begin
            SD_CSn  = init_csn;
            SD_MOSI = init_mosi;
         end
         ST_GRANT_RD: begin
            SD_CSn  = rd_csn;
            SD_MOSI = rd_mosi;
         end
         ST_GRANT_WR: begin
            SD_CSn  = wr_csn;
            SD_MOSI = wr_mosi;
         end
         default: begin
            SD_CSn  = 1'b1;
            SD_MOSI = 1'b1;
         end
      endcase
   end

   assign rd_gnt   = rd_gnt_q;
   assign wr_gnt   = wr_gnt_q;
   assign rd_abort = rd_abort_q;
   assign wr_abort = wr_abort_q;
   assign owner    = owner_q;

endmodule

// File: tb/tb_sd_bus_arbiter.sv
// Self-checking bench for sd_bus_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_sd_bus_arbiter;

   localparam int GAP = 8;
   localparam int TO  = 64;

   logic       SD_CK = 1'b0;
   logic       rst_n = 1'b1;
   logic       init_ok = 1'b0, init_csn = 1'b1, init_mosi = 1'b1;
   logic       rd_req = 1'b0, rd_done = 1'b0, rd_csn = 1'b1, rd_mosi = 1'b1;
   logic       wr_req = 1'b0, wr_done = 1'b0, wr_csn = 1'b1, wr_mosi = 1'b1;
   logic       rd_gnt, wr_gnt, rd_abort, wr_abort, SD_CSn, SD_MOSI;
   logic [1:0] owner;

   sd_bus_arbiter #(
      .IDLE_GAP    (GAP),
      .TIMEOUT_CYC (TO)
   ) dut (
      .SD_CK     (SD_CK),
      .rst_n     (rst_n),
      .init_ok   (init_ok),
      .init_csn  (init_csn),
      .init_mosi (init_mosi),
      .rd_req    (rd_req),
      .rd_done   (rd_done),
      .rd_csn    (rd_csn),
      .rd_mosi   (rd_mosi),
      .wr_req    (wr_req),
      .wr_done   (wr_done),
      .wr_csn    (wr_csn),
      .wr_mosi   (wr_mosi),
      .rd_gnt    (rd_gnt),
      .wr_gnt    (wr_gnt),
      .rd_abort  (rd_abort),
      .wr_abort  (wr_abort),
      .SD_CSn    (SD_CSn),
      .SD_MOSI   (SD_MOSI),
      .owner     (owner)
   );

   always #5 SD_CK = ~SD_CK;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: who owns the bus, idle cycles still owed, cycles held, who was served last.
   int m_owner, m_gap, m_held, m_last;
   logic m_rd_ab, m_wr_ab;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = 1; m_gap = 0; m_held = 0; m_last = 3;
      m_rd_ab = 1'b0; m_wr_ab = 1'b0;
   endtask

   task automatic model_abort(input int who);
      if (who == 2) m_rd_ab = 1'b1;
      else          m_wr_ab = 1'b1;
   endtask

   // One falling edge of the model using the inputs the DUT sees at that edge.
   task automatic model_step();
      logic done;
      m_rd_ab = 1'b0;
      m_wr_ab = 1'b0;
      if (m_owner == 1) begin
         if (init_ok) begin
            m_owner = 0;
            m_gap   = GAP;
         end
      end else if (m_owner == 0) begin
         if (!init_ok) m_owner = 1;
         else if (m_gap > 0) m_gap--;
         else if (rd_req && wr_req) begin
            m_owner = (m_last == 2) ? 3 : 2;
            m_held  = 0;
         end else if (rd_req) begin
            m_owner = 2; m_held = 0;
         end else if (wr_req) begin
            m_owner = 3; m_held = 0;
         end
      end else begin
         done = (m_owner == 2) ? rd_done : wr_done;
         if (!init_ok) begin
            model_abort(m_owner);
            m_owner = 1;
         end else if (done) begin
            m_last  = m_owner;
            m_owner = 0;
            m_gap   = GAP;
         end else if (m_held == TO - 1) begin
            model_abort(m_owner);
            m_owner = 0;
            m_gap   = GAP;
         end else begin
            m_held++;
         end
      end
   endtask

   task automatic check_all();
      logic e_csn, e_mosi;
      case (m_owner)
         1:       begin e_csn = init_csn; e_mosi = init_mosi; end
         2:       begin e_csn = rd_csn;   e_mosi = rd_mosi;   end
         3:       begin e_csn = wr_csn;   e_mosi = wr_mosi;   end
         default: begin e_csn = 1'b1;     e_mosi = 1'b1;      end
      endcase
      chk("owner",    16'(owner),    16'(m_owner));
      chk("rd_gnt",   16'(rd_gnt),   16'(m_owner == 2));
      chk("wr_gnt",   16'(wr_gnt),   16'(m_owner == 3));
      chk("rd_abort", 16'(rd_abort), 16'(m_rd_ab));
      chk("wr_abort", 16'(wr_abort), 16'(m_wr_ab));
      chk("sd_csn",   16'(SD_CSn),   16'(e_csn));
      chk("sd_mosi",  16'(SD_MOSI),  16'(e_mosi));
   endtask

   task automatic tick();
      @(negedge SD_CK);
      if (rst_n) model_step();
      #1;
      check_all();
   endtask

   function automatic logic gnt_seen(input int which);
      if (which == 2) return rd_gnt;
      if (which == 3) return wr_gnt;
      return rd_gnt | wr_gnt;
   endfunction

   // Ticks until the selected grant is seen, bounded by budget.
   task automatic wait_for(input int which, input int budget, output int n);
      n = 0;
      while (!gnt_seen(which) && n < budget) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int n;
      model_reset();
      #1 rst_n = 1'b0;
      #2;
      check_all();
      chk("reset_owner", 16'(owner), 16'd1);
      chk("reset_gnt",   16'({rd_gnt, wr_gnt, rd_abort, wr_abort}), 16'd0);
      repeat (2) @(negedge SD_CK);
      #1 rst_n = 1'b1;

      // Initialiser owns the bus until init_ok
      for (int i = 0; i < 99; i++) begin
         init_csn  = 1'($urandom);
         init_mosi = 1'($urandom);
         tick();
      end
      chk("init_owner_hold", 16'(owner), 16'd1);
      init_csn = 1'b1; init_mosi = 1'b1;
      init_ok = 1'b1;
      rd_req  = 1'b1;
      tick();
      chk("gap_owner", 16'(owner), 16'd0);
      chk("gap_csn",   16'(SD_CSn), 16'd1);
      wait_for(2, 40, n);
      chk("init_to_rd_gnt", 16'(n), 16'(GAP + 1));
      rd_req = 1'b0;

      // Read held 50 grant cycles, then done
      for (int i = 0; i < 49; i++) begin
         rd_csn  = 1'($urandom);
         rd_mosi = 1'($urandom);
         tick();
      end
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      chk("done_gnt_drop", 16'(rd_gnt), 16'd0);
      chk("done_csn_high", 16'({SD_CSn, SD_MOSI}), 16'd3);
      wr_req = 1'b1;
      wait_for(3, 40, n);
      chk("done_to_next_gnt", 16'(n), 16'(GAP + 1));
      wr_req = 1'b0;
      tick();
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;

      // Both requesting: strict alternation, write was served last
      rd_req = 1'b1; wr_req = 1'b1;
      for (int t = 0; t < 4; t++) begin
         wait_for(0, 40, n);
         chk("alt_gap",   16'(n), 16'(GAP + 1));
         chk("alt_owner", 16'(owner), 16'((t % 2 == 0) ? 2 : 3));
         repeat (3) tick();
         if (rd_gnt) rd_done = 1'b1;
         else        wr_done = 1'b1;
         tick();
         rd_done = 1'b0; wr_done = 1'b0;
      end
      rd_req = 1'b0; wr_req = 1'b0;
      repeat (12) tick();

      // Watchdog timeout on the write grant
      wr_req = 1'b1;
      wait_for(3, 40, n);
      chk("to_gnt", 16'(wr_gnt), 16'd1);
      wr_req = 1'b0;
      repeat (TO - 1) tick();
      chk("to_still_gnt", 16'(wr_gnt), 16'd1);
      tick();
      chk("to_abort",     16'(wr_abort), 16'd1);
      chk("to_gnt_drop",  16'(wr_gnt),   16'd0);
      chk("to_owner_gap", 16'(owner),    16'd0);
      tick();
      chk("to_abort_1cyc", 16'(wr_abort), 16'd0);

      // Done on the timeout cycle wins, no abort
      repeat (10) tick();
      wr_req = 1'b1;
      wait_for(3, 40, n);
      wr_req = 1'b0;
      repeat (TO - 1) tick();
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      chk("done_vs_to_abort", 16'(wr_abort), 16'd0);
      chk("done_vs_to_gnt",   16'(wr_gnt),   16'd0);
      repeat (12) tick();

      // init_ok loss during a read grant
      rd_req = 1'b1;
      wait_for(2, 40, n);
      rd_req = 1'b0;
      wr_req = 1'b1;
      repeat (5) tick();
      init_ok = 1'b0; init_csn = 1'b0; init_mosi = 1'b0;
      tick();
      chk("loss_abort", 16'(rd_abort), 16'd1);
      chk("loss_gnt",   16'(rd_gnt),   16'd0);
      chk("loss_owner", 16'(owner),    16'd1);
      chk("loss_bus",   16'({SD_CSn, SD_MOSI}), 16'd0);
      init_csn = 1'b1;
      tick();
      chk("loss_abort_1cyc", 16'(rd_abort), 16'd0);
      for (int i = 0; i < 20; i++) begin
         init_mosi = 1'($urandom);
         tick();
         chk("loss_no_wr_gnt", 16'(wr_gnt), 16'd0);
      end
      init_mosi = 1'b1;
      init_ok = 1'b1;
      wait_for(3, 40, n);
      chk("reinit_to_wr_gnt", 16'(n), 16'(GAP + 2));
      wr_req = 1'b0;
      tick();
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         init_ok   = ($urandom_range(0, 299) != 0);
         init_csn  = 1'($urandom);
         init_mosi = 1'($urandom);
         rd_req    = ($urandom_range(0, 2) != 0);
         wr_req    = ($urandom_range(0, 2) != 0);
         rd_done   = ($urandom_range(0, 15) == 0);
         wr_done   = ($urandom_range(0, 15) == 0);
         rd_csn    = 1'($urandom);
         rd_mosi   = 1'($urandom);
         wr_csn    = 1'($urandom);
         wr_mosi   = 1'($urandom);
         tick();
      end
      init_ok = 1'b1; init_csn = 1'b1; init_mosi = 1'b1;
      rd_req = 1'b0; wr_req = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
      repeat (TO + 2 * GAP) tick();

      // Asynchronous reset in the middle of a write grant
      wr_req = 1'b1;
      wait_for(3, 40, n);
      chk("rst_pre_gnt", 16'(wr_gnt), 16'd1);
      wr_req = 1'b0;
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_async_gnt",   16'(wr_gnt), 16'd0);
      chk("rst_async_owner", 16'(owner),  16'd1);
      check_all();
      tick();
      rst_n  = 1'b1;
      rd_req = 1'b1;
      tick();
      wait_for(2, 40, n);
      chk("rst_resume_rd_gnt", 16'(n), 16'(GAP + 1));
      rd_req = 1'b0;
      tick();
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sd_bus_arbiter.md
# sd_bus_arbiter

Owns the single SD-card SPI bus (SD_CSn, SD_MOSI) and shares it between three masters: the card initialiser, the block-read engine and the block-write engine. The initialiser has exclusive use of the bus until `init_ok` is high. After that, read and write requests are granted round-robin. Each ownership change is separated by an idle gap of at least 8 clocks with CSn high, as the SD protocol requires. A watchdog revokes any grant that is held too long.

## Interface
Parameters:
- `IDLE_GAP`, default 8: SD_CK cycles with CSn=1 and MOSI=1 between grants; legal range 8..255.
- `TIMEOUT_CYC`, default 4095: maximum SD_CK cycles one grant may be held; legal range 64..65535.

Ports:
- `SD_CK` in 1: SPI clock; all state updates on its falling edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `init_ok` in 1: initialiser finished; level.
- `init_csn`, `init_mosi` in 1 each: initialiser bus drive.
- `rd_req` in 1: read engine requests the bus; level, held until granted.
- `rd_done` in 1: one-cycle pulse from the read engine while granted; releases the bus.
- `rd_csn`, `rd_mosi` in 1 each: read engine bus drive.
- `wr_req`, `wr_done`, `wr_csn`, `wr_mosi` in 1 each: same as the read set, for the write engine.
- `rd_gnt`, `wr_gnt` out 1: grant levels; registered.
- `rd_abort`, `wr_abort` out 1: one-cycle pulse when a grant is revoked by timeout or by `init_ok` loss.
- `SD_CSn`, `SD_MOSI` out 1: muxed bus to the card.
- `owner` out 2: current owner: 0 none, 1 init, 2 rd, 3 wr.

## Operation
States:
- **INIT**: owner=1. The bus is driven by `init_csn`/`init_mosi`.
  - `init_ok`=1 → GAP.
- **GAP**: owner=0. CSn=1, MOSI=1. The gap counter is loaded with IDLE_GAP-1 on entry.
  - Counter reaches 0 → IDLE.
  - `init_ok`=0 at any time → INIT.
- **IDLE**: owner=0. CSn=1, MOSI=1.
  - `rd_req` only → GRANT_RD.
  - `wr_req` only → GRANT_WR.
  - Both requesting → the one not served last; `last` resets to WR, so RD wins the first tie.
  - `init_ok`=0 → INIT; this has priority over requests.
- **GRANT_RD / GRANT_WR**: owner=2/3. The matching gnt is 1 and the bus is driven by that engine's csn/mosi. The watchdog counts up from 0.
  - `done`=1 → GAP. `last` is updated. No abort.
  - Watchdog reaches TIMEOUT_CYC-1 without `done` → abort pulse, then GAP.
  - `init_ok`=0 → abort pulse, then INIT. This has priority over `done` and timeout in the same cycle.

Other rules:
- If `done` and timeout occur in the same cycle, `done` wins and no abort is issued.
- `done` from the non-granted engine is ignored. `req` while already granted is ignored.
- Bus mux is combinational from the registered state; there is no combinational path from req/done to SD_CSn.
- Reset value of every output: `rd_gnt`=0, `wr_gnt`=0, `rd_abort`=0, `wr_abort`=0, `owner`=1. State resets to INIT, so SD_CSn and SD_MOSI follow `init_csn`/`init_mosi`, which the initialiser itself resets to 1.

## Timing
- Inputs are sampled and outputs update on negedge SD_CK.
- req → gnt: 1 cycle from the first negedge at which IDLE samples req=1.
- done → gnt=0 and CSn=1: 1 cycle. The next gnt comes no earlier than IDLE_GAP+1 cycles later.
- The abort pulse coincides with gnt falling, lasts exactly 1 cycle, and is never asserted together with gnt.
- Watchdog width is 16 bits and saturates. It clears on every grant entry.
- Gap counter width is 8 bits.
- Asynchronous reset mid-grant: gnt drops immediately and the block returns to INIT. The engines must treat gnt loss as an abort.

## Structure
- Shared package `sd_pkg`:
  - state encoding (INIT, GAP, IDLE, GRANT_RD, GRANT_WR) as localparams;
  - owner codes 0..3;
  - `SD_MIN_GAP`=8.
- One sub-module, `sd_down_counter`: loadable, saturating-at-0 counter with a `zero` flag, parameterised width. Used for the gap counter. The watchdog is an inline up-counter.

## Test plan
- Reset then `init_ok` rises at cycle 100 → owner 1 until then; CSn=1 for exactly 8 cycles; owner=0 in IDLE.
- `rd_req` alone in IDLE → `rd_gnt`=1 one negedge later. `rd_done` at grant cycle 50 → `rd_gnt`=0 next cycle; CSn=1, MOSI=1 for 8 cycles.
- `rd_req` and `wr_req` both held → grants alternate RD, WR, RD, WR across 4 transactions, each separated by ≥8 idle cycles.
- TIMEOUT_CYC=64, `wr_req` granted with no done → `wr_abort` 1-cycle pulse at grant cycle 64, `wr_gnt`=0, then GAP. Check the same-cycle variant where `wr_done` arrives on the timeout cycle: no abort.
- `init_ok` drops during GRANT_RD → `rd_abort` pulse, owner=1 next cycle, bus follows `init_csn`. `wr_req` held meanwhile gets no grant until `init_ok` returns and a further 8 cycles have passed.
- `rst_n` asserted mid-GRANT_WR → `wr_gnt`=0 asynchronously, owner=1. After release, normal flow resumes from INIT.
